// File: rtl/memory_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dual_port_memory                                              |
// | Purpose  : Simple dual-port RAM, one write port and one registered read  |
// |            port, each with its own clock and clock enable.               |
// | Ports    : write_clock/write_clock_enable/write_enable/write_address/    |
// |            write_data   - write port, data stored on the rising edge     |
// |            read_clock/read_clock_enable/read_enable/read_address        |
// |            read_data    - read port, data valid after the read edge      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dual_port_memory #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     write_clock,
  input  logic                     write_clock_enable,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_clock,
  input  logic                     read_clock_enable,
  input  logic                     read_enable,
  input  logic [$clog2(DEPTH)-1:0] read_address,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] read_data_d;
  logic [WIDTH-1:0] read_data_q;

  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    if (read_clock_enable && read_enable) begin
      read_data_d = mem[read_address];
    end
  end

  always_ff @(posedge read_clock) begin
    read_data_q <= read_data_d;
  end

  assign read_data = read_data_q;

endmodule

// +--------------------------------------------------------------------------+
// | Module   : memory_fifo                                                   |
// | Purpose  : Valid/ready FIFO built on a synchronous-read dual-port RAM,   |
// |            followed by a 2-entry output stage that hides the RAM read    |
// |            latency and sustains one word per cycle in each direction.    |
// | Ports    : clock     - single clock for all logic                        |
// |            reset     - asynchronous, active-high                         |
// |            in_valid/in_ready/in_data    - producer side                  |
// |            out_valid/out_ready/out_data - consumer side (head word)      |
// |            count     - words held (memory + read in flight + stage)      |
// |            empty     - count == 0                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module memory_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH)+1:0] count,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;
  localparam int c_cw = c_aw + 2;
  localparam logic [c_pw-1:0] c_depth_ptr = c_pw'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // Registered state
  logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;
  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [c_cw-1:0]  count_q, count_d;

  // Combinational helpers
  logic [c_pw-1:0]  w_occupancy;
  logic             w_write_enable;
  logic             w_read_enable;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [1:0]       w_entries;
  logic [1:0]       w_pending;
  logic [WIDTH-1:0] w_rd_data;

  // Pointers carry one extra bit so full (difference == DEPTH) and empty
  // (difference == 0) are distinguishable.
  assign w_occupancy = wr_ptr_q - rd_ptr_q;

  // Only registered state feeds in_ready; reset gates it so nothing is
  // accepted while the block is held in reset.
  assign in_ready       = (w_occupancy < c_depth_ptr) && !reset;
  assign w_write_enable = in_valid && in_ready;
  assign w_in_fire      = w_write_enable;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = entry0_q;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    case (state_q)
      ST_ONE:  w_entries = 2'd1;
      ST_TWO:  w_entries = 2'd2;
      default: w_entries = 2'd0;
    endcase
  end

  // Slots the output stage will need after this edge. A read is launched
  // only when that leaves room, so a capture never lands on a full stage.
  // out_fire implies at least one entry, so the subtraction cannot underflow.
  assign w_pending     = w_entries + {1'b0, inflight_q} - {1'b0, w_out_fire};
  // A word written at edge N is counted in occupancy only after edge N, so
  // the first read of it is at N+1 and never collides with its own write.
  assign w_read_enable = (w_occupancy != '0) && (w_pending <= 2'd1);

  dual_port_memory #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (w_write_enable),
    .write_address      (wr_ptr_q[c_aw-1:0]),
    .write_data         (in_data),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (w_read_enable),
    .read_address       (rd_ptr_q[c_aw-1:0]),
    .read_data          (w_rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q + c_pw'(w_write_enable);
    rd_ptr_d   = rd_ptr_q + c_pw'(w_read_enable);
    inflight_d = w_read_enable;
    count_d    = count_q + c_cw'(w_in_fire) - c_cw'(w_out_fire);
  end

  // Output stage: entry0 is always the head. inflight_q marks that the RAM
  // read data is valid this cycle and must be captured at this edge.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state_q)
      ST_EMPTY: begin
        if (inflight_q) begin
          state_d  = ST_ONE;
          entry0_d = w_rd_data;
        end
      end
      ST_ONE: begin
        if (inflight_q) begin
          if (w_out_fire) begin
            // Head leaves and the new word replaces it in the same edge.
            entry0_d = w_rd_data;
          end else begin
            state_d  = ST_TWO;
            entry1_d = w_rd_data;
          end
        end else if (w_out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          state_d  = ST_ONE;
          entry0_d = entry1_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      state_q    <= ST_EMPTY;
      entry0_q   <= '0;
      entry1_q   <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      count_q    <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_memory_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_memory_fifo                                                |
// | Purpose  : Directed self-checking bench for memory_fifo (WIDTH=16,       |
// |            DEPTH=256): reset, single word, streaming, fill, full-edge    |
// |            simultaneity, pointer wrap, asynchronous reset.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_memory_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [9:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;
  int bad_order;
  int pushed;
  int popped;
  logic [15:0] exp_w;
  logic [15:0] q [$];

  memory_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Single word: write E0, read E1, capture E2, pop E3
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_count_e0", 32'(count), 32'd1);
    check("single_valid_e0", 32'(out_valid), 32'd0);
    tick();
    check("single_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("single_valid_e2", 32'(out_valid), 32'd1);
    check("single_data_e2", 32'(out_data), 32'hA5A5);
    check("single_count_e2", 32'(count), 32'd1);
    tick();
    check("single_count_e3", 32'(count), 32'd0);
    check("single_empty_e3", 32'(empty), 32'd1);
    check("single_valid_e3", 32'(out_valid), 32'd0);

    // Streaming: push at edges 0..999, pop of word j-3 at edge j (3..1002)
    bad = 0; bad_order = 0;
    out_ready = 1'b1;
    for (int j = 0; j < 1006; j++) begin
      in_valid = (j < 1000);
      in_data  = 16'(j);
      if (out_valid !== ((j >= 3) && (j <= 1002))) bad++;
      if ((j >= 3) && (j <= 1002) && (out_data !== 16'(j - 3))) bad_order++;
      if ((j < 1000) && (in_ready !== 1'b1)) bad++;
      if (j == 500) check("stream_count_steady", 32'(count), 32'd3);
      tick();
    end
    in_valid = 1'b0;
    check("stream_bubbles", 32'(bad), 32'd0);
    check("stream_order", 32'(bad_order), 32'd0);
    check("stream_count_end", 32'(count), 32'd0);

    // Fill with consumer stalled
    out_ready = 1'b0; in_valid = 1'b1; n = 0;
    for (int k = 0; k < 400; k++) begin
      if (in_ready !== 1'b1) break;
      in_data = 16'h1000 + 16'(n);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("fill_accepted", 32'(n), 32'd258);
    check("fill_count", 32'(count), 32'd258);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_head", 32'(out_data), 32'h1000);
    check("fill_empty", 32'(empty), 32'd0);

    // Full boundary: push and pop offered together while full
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
    check("full_in_ready_pre", 32'(in_ready), 32'd0);
    tick();
    check("full_simul_count", 32'(count), 32'd257);
    check("full_next_head", 32'(out_data), 32'h1001);
    check("full_in_ready_rise", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("full_refill_count", 32'(count), 32'd258);

    // Drain: 0x1001..0x1101 then 0xBEEF
    out_ready = 1'b1; n = 0; bad = 0;
    for (int k = 0; k < 600; k++) begin
      if (count == 10'd0) break;
      if (out_valid === 1'b1) begin
        exp_w = (n < 257) ? (16'h1001 + 16'(n)) : 16'hBEEF;
        if (out_data !== exp_w) bad++;
        n++;
      end
      tick();
    end
    check("drain_words", 32'(n), 32'd258);
    check("drain_order", 32'(bad), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);

    // Wrap: random valid/ready against a queue model
    q.delete(); bad = 0; pushed = 0; popped = 0;
    for (int k = 0; k < 6000; k++) begin
      if ((pushed == 600) && (popped == 600)) break;
      in_valid  = (pushed < 600) && ($urandom_range(0, 1) == 1);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if ((q.size() < DEPTH) && (in_ready !== 1'b1)) bad++;
      if ((q.size() == 0) && (out_valid !== 1'b0)) bad++;
      if ((out_valid === 1'b1) && out_ready) begin
        if (q.size() == 0) begin
          bad++;
        end else begin
          exp_w = q.pop_front();
          if (out_data !== exp_w) bad++;
        end
        popped++;
      end
      if (in_valid && (in_ready === 1'b1)) begin
        q.push_back(in_data);
        pushed++;
      end
      tick();
      if (count !== 10'(q.size())) bad++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_model", 32'(bad), 32'd0);
    check("wrap_popped", 32'(popped), 32'd600);
    check("wrap_count_end", 32'(count), 32'd0);

    // Asynchronous reset with 37 words held
    in_valid = 1'b1;
    for (int k = 0; k < 37; k++) begin
      in_data = 16'h2000 + 16'(k);
      tick();
    end
    in_valid = 1'b0;
    check("areset_pre_count", 32'(count), 32'd37);
    check("areset_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd0);
    check("areset_empty", 32'(empty), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("areset_release_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 16'h5A5A; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_reset_count", 32'(count), 32'd1);
    tick();
    tick();
    check("post_reset_valid", 32'(out_valid), 32'd1);
    check("post_reset_data", 32'(out_data), 32'h5A5A);
    tick();
    check("post_reset_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_fifo.md
MEMORY_FIFO -- requirements
Module: memory_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits; legal values 1..16.
REQ-002 SHALL have parameter DEPTH, default 256: memory words; power of two, 2..256.
REQ-003 SHALL have port clock, input, 1: single clock for all logic; one clock, shared by the memory read and write ports.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: producer has a word.
REQ-006 SHALL have port in_ready, output, 1: block accepts a word.
REQ-007 SHALL have port in_data, input, WIDTH: producer word.
REQ-008 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the word.
REQ-010 SHALL have port out_data, output, WIDTH: head word.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+2: total words held (memory + in flight + output stage).
REQ-012 SHALL have port empty, output, 1: count == 0.

Function
REQ-013 SHALL store words in one dual_port_memory instance (WIDTH, DEPTH), with both port clocks = clock and both clock enables tied 1.
REQ-014 SHALL define a transfer as valid&ready high at a rising edge; in_data SHALL be written at wr_ptr on the input-transfer edge.
REQ-015 SHALL keep wr_ptr and rd_ptr at $clog2(DEPTH)+1 bits; address = low bits; memory occupancy = wr_ptr - rd_ptr, modulo wrap.
REQ-016 SHALL drive in_ready = 1 iff memory occupancy < DEPTH and reset is low; combinational from registered state only.
REQ-017 SHALL treat a memory word as readable only from the edge after its write edge; same-address read-during-write SHALL never occur.
REQ-018 SHALL have a 2-entry output stage with states EMPTY, ONE, TWO; out_valid = (state != EMPTY); out_data = oldest entry.
REQ-019 SHALL issue a read (read_enable=1, rd_ptr increments) at an edge iff memory occupancy > 0 and (output entries + reads in flight - output transfer at that edge) <= 1.
REQ-020 SHALL capture read data at the edge following the read edge: EMPTY->ONE, or ONE->TWO when no output transfer, or ONE stays ONE when an output transfer occurs at that edge.
REQ-021 SHALL move TWO->ONE on an output transfer with no capture, and ONE->EMPTY on an output transfer with no capture; TWO with capture SHALL not occur (guaranteed by REQ-019).
REQ-022 SHALL give latency 2 edges from input transfer into an empty block to out_valid high (write E0, read E1, capture E2).
REQ-023 SHALL sustain one transfer per cycle on each side simultaneously when in_valid and out_ready are held high.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL when full: accept a simultaneous input transfer only if in_ready was already high at that edge; no overwrite; occupancy never exceeds DEPTH.
REQ-026 SHALL update count each edge by +input transfer - output transfer; maximum count DEPTH+2.
REQ-027 SHALL ignore in_data when in_valid=0, and ignore out_ready when out_valid=0.

Reset
REQ-028 SHALL, while reset is high, force wr_ptr=0, rd_ptr=0, no read in flight, state EMPTY, out_valid=0, in_ready=0, count=0, empty=1, read_enable=0, write_enable=0.
REQ-029 SHALL make reset asserted mid-transfer discard all contents immediately, without waiting for a clock; out_data SHALL be don't-care while out_valid=0.
REQ-030 SHALL raise in_ready combinationally when reset is released; the first transfer is possible at the first edge after release.

Verification
REQ-031 SHALL test a single word: write 16'hA5A5 into empty (DEPTH=256), out_ready=1 -> out_valid high exactly 2 edges later with 16'hA5A5; count 1->0; empty returns to 1.
REQ-032 SHALL test streaming: 1000 sequential values, in_valid=1, out_ready=1 -> output order identical; after warm-up, one word out per cycle with no bubbles.
REQ-033 SHALL test fill: out_ready=0, push until in_ready=0 -> exactly 258 words accepted (256 memory + 2 output), count=258; first pop yields the first word.
REQ-034 SHALL test wrap: 600 words pushed/popped with random valid/ready (50%) -> data order preserved across pointer wrap; count matches a reference model every cycle.
REQ-035 SHALL test full-boundary simultaneity: at occupancy DEPTH with out_valid=1, assert in_valid and out_ready together -> pop occurs, push is refused that edge, and in_ready rises at a later edge.
REQ-036 SHALL test async reset mid-stream: assert reset between edges with count=37 -> out_valid=0, count=0, in_ready=0 before the next edge; normal operation after release.
